instruction_fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 90 +++++++++
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch state machine encoding (IDLE, RUN, FAULT)
//   NOP_INSTR     : instruction shown on the decode interface after reset
//   DEFAULT_TEXT_BASE : byte address of ROM word 0 on the default memory map
//   fetch_entry_t : one prefetch entry {pc, instr} for the default 32-bit width
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
    localparam int          ENTRY_DATA_W      = 32;

    typedef struct packed {
        logic [31:0]             pc;
        logic [ENTRY_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with a registered head output.
//   clk, reset      : clock, asynchronous active-low reset
//   push_i/push_data_i : write request and data (ignored when flushing)
//   pop_i           : consume the head entry (ignored when empty)
//   flush_i         : discard every entry; a pop in the same cycle is harmless
//   full_o/empty_o  : occupancy flags
//   head_o          : registered copy of the oldest entry; holds when empty
module fetch_fifo #(
    parameter int                 WIDTH      = 64,
    parameter int                 DEPTH      = 2,
    parameter logic [WIDTH-1:0]   RESET_HEAD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    logic             pop_eff;
    logic             push_eff;
    logic [CNT_W-1:0] count_after_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_eff         = pop_i && !empty_o;
    assign push_eff        = push_i && !flush_i && (!full_o || pop_eff);
    assign count_after_pop = count_q - CNT_W'(pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_eff);
            count_d  = count_after_pop + CNT_W'(push_eff);
            // The next head is either an entry already stored behind the
            // current one, or the incoming word when the FIFO drains to empty.
            if (count_after_pop != '0) begin
                head_d = mem[rd_ptr_d];
            end else if (push_eff) begin
                head_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= RESET_HEAD;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC generation and prefetch in front of Program_Memory.
//   clk, reset        : clock, asynchronous active-low reset
//   Instruction_i     : ROM data for Rom_Address_o, same cycle
//   Rom_Address_o     : ROM word index of the current fetch PC
//   Redirect_i/Redirect_PC_i : taken branch/jump and its target byte address
//   Ready_i           : decode accepts the head entry
//   Valid_o, Instruction_o, PC_o, PC_Plus4_o : registered head of the prefetch FIFO
//   Fault_o           : fetch halted on a misaligned or out-of-range target
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           Instruction_i,
    output logic [$clog2(MEMORY_DEPTH)-1:0] Rom_Address_o,
    input  logic                            Redirect_i,
    input  logic [31:0]                     Redirect_PC_i,
    input  logic                            Ready_i,
    output logic                            Valid_o,
    output logic [DATA_WIDTH-1:0]           Instruction_o,
    output logic [31:0]                     PC_o,
    output logic [31:0]                     PC_Plus4_o,
    output logic                            Fault_o
);

    localparam int          ADDR_W    = $clog2(MEMORY_DEPTH);
    localparam int          ENTRY_W   = 32 + DATA_WIDTH;
    localparam logic [31:0] ROM_BYTES = 32'(MEMORY_DEPTH) << 2;
    localparam logic [ENTRY_W-1:0] RESET_HEAD = {RESET_PC, DATA_WIDTH'(NOP_INSTR)};

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         fault_q;

    logic               fetch_ok;
    logic               slot_free;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    // A fetch target is usable only if word aligned and inside the ROM window.
    // The offset is taken modulo 2^32, so addresses below TEXT_BASE are
    // rejected explicitly rather than relying on the wrapped offset.
    function automatic logic pc_ok(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - TEXT_BASE;
        return (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && (off < ROM_BYTES);
    endfunction

    assign Rom_Address_o = ADDR_W'((fetch_pc_q - TEXT_BASE) >> 2);

    assign fetch_ok  = pc_ok(fetch_pc_q);
    assign pop       = Valid_o && Ready_i;
    assign slot_free = !fifo_full || pop;
    assign push      = (state_q == ST_RUN) && !Redirect_i && fetch_ok && slot_free;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (Redirect_i) begin
            // The target is checked as it arrives so a bad redirect faults
            // at the redirect edge itself.
            fetch_pc_d = Redirect_PC_i;
            state_d    = pc_ok(Redirect_PC_i) ? ST_RUN : ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (!fetch_ok) begin
                        state_d = ST_FAULT;
                    end else if (slot_free) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    fetch_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (FIFO_DEPTH),
        .RESET_HEAD (RESET_HEAD)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({fetch_pc_q, Instruction_i}),
        .pop_i       (pop),
        .flush_i     (Redirect_i),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign Valid_o                = !fifo_empty;
    assign {PC_o, Instruction_o}  = head;
    assign PC_Plus4_o             = PC_o + 32'd4;
    assign Fault_o                = fault_q;

endmodule
